// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch front end. It issues one request at a time to an
// instruction memory, hands each returned instruction to decode with its PC,
// and steers the fetch stream on traps, exception returns and redirects.
// It also holds the exception PC/cause registers (mepc/mcause).
//
// Ports
//   clk           in   sole clock, rising edge
//   resetb        in   asynchronous active-low reset
//   im_req        out  fetch request (held until im_ack)
//   im_addr       out  fetch address (stable while a request is open)
//   im_ack        in   instruction returned this cycle
//   im_do         in   instruction data
//   fd_valid      out  instruction valid to decode
//   fd_instr      out  instruction to decode
//   fd_pc         out  PC of fd_instr
//   fd_stall      in   decode not accepting
//   redir_valid   in   branch/jump redirect
//   redir_target  in   redirect address
//   redir_src_pc  in   PC of the redirecting instruction
//   trap_valid    in   exception from execute
//   trap_pc       in   faulting PC
//   trap_cause    in   cause code
//   mret          in   return from exception
//   mepc          out  exception PC register
//   mcause        out  exception cause register
//
// Flush priority is trap_valid > mret > redir_valid. A redirect to a target
// that is not IALIGN-aligned is turned into a trap with cause 0. IALIGN must
// be 2 or 4.
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0004,
  parameter int unsigned     IALIGN       = 4
) (
  input  logic            clk,
  input  logic            resetb,
  output logic            im_req,
  output logic [XLEN-1:0] im_addr,
  input  logic            im_ack,
  input  logic [31:0]     im_do,
  output logic            fd_valid,
  output logic [31:0]     fd_instr,
  output logic [XLEN-1:0] fd_pc,
  input  logic            fd_stall,
  input  logic            redir_valid,
  input  logic [XLEN-1:0] redir_target,
  input  logic [XLEN-1:0] redir_src_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_cause,
  input  logic            mret,
  output logic [XLEN-1:0] mepc,
  output logic [XLEN-1:0] mcause
);

  localparam logic [XLEN-1:0] ALIGN_STEP = XLEN'(IALIGN);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);

  typedef enum logic [1:0] {
    S_BOOT,
    S_FETCH,
    S_HOLD
  } state_t;

  state_t          r_state;
  logic            r_req;
  logic [XLEN-1:0] r_pc;         // address of the open (or next) fetch
  logic            r_pend_valid; // flush seen while a fetch was open
  logic [XLEN-1:0] r_pend_pc;    // where to fetch once that fetch returns
  logic            r_fd_valid;
  logic [31:0]     r_fd_instr;
  logic [XLEN-1:0] r_fd_pc;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;

  logic            w_ack;
  logic            w_stalled;
  logic            w_flush;
  logic            w_redir_misaligned;
  logic [XLEN-1:0] w_flush_pc;
  logic            w_csr_we;
  logic [XLEN-1:0] w_csr_epc;
  logic [XLEN-1:0] w_csr_cause;

  assign w_ack     = r_req & im_ack;
  assign w_stalled = r_fd_valid & fd_stall;

  // Flush resolution: pick the winning event, its target and any CSR write.
  // NOTE: every signal written here gets a default first, so no latch can be
  // inferred whichever branch is taken.
  always_comb begin
    w_flush            = trap_valid | mret | redir_valid;
    w_redir_misaligned = redir_valid & ((redir_target & ALIGN_MASK) != '0);
    w_flush_pc         = redir_target;
    w_csr_we           = 1'b0;
    w_csr_epc          = trap_pc;
    w_csr_cause        = trap_cause;
    if (trap_valid) begin
      w_flush_pc = TRAP_VECTOR;
      w_csr_we   = 1'b1;
    end else if (mret) begin
      w_flush_pc = r_mepc;
    end else if (w_redir_misaligned) begin
      w_flush_pc  = TRAP_VECTOR;
      w_csr_we    = 1'b1;
      w_csr_epc   = redir_src_pc;
      w_csr_cause = '0;
    end
  end

  // NOTE: all state here uses nonblocking assignments so every register
  // samples the pre-edge values and update order within the block is moot.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_state      <= S_BOOT;
      r_req        <= 1'b0;
      r_pc         <= RESET_VECTOR;
      r_pend_valid <= 1'b0;
      r_pend_pc    <= '0;
      r_fd_valid   <= 1'b0;
      r_fd_instr   <= '0;
      r_fd_pc      <= '0;
      r_mepc       <= '0;
      r_mcause     <= '0;
    end else begin
      case (r_state)
        S_BOOT: begin
          // Any im_ack seen here belongs to a fetch abandoned by reset.
          r_state <= S_FETCH;
          r_req   <= 1'b1;
        end

        S_FETCH: begin
          if (w_flush) begin
            r_fd_valid <= 1'b0;
            if (w_ack) begin
              // The returning instruction is on the wrong path: drop it and
              // request the new target right away.
              r_pc         <= w_flush_pc;
              r_pend_valid <= 1'b0;
            end else begin
              // The memory still owes us an answer for im_addr, so keep the
              // request stable and park the target; a later flush overwrites.
              r_pend_valid <= 1'b1;
              r_pend_pc    <= w_flush_pc;
            end
          end else if (w_ack) begin
            if (r_pend_valid) begin
              r_pc         <= r_pend_pc;
              r_pend_valid <= 1'b0;
              r_fd_valid   <= 1'b0;
            end else if (w_stalled) begin
              // No room for this instruction; pc is not advanced, so it is
              // fetched again once decode drains.
              r_state <= S_HOLD;
              r_req   <= 1'b0;
            end else begin
              r_fd_valid <= 1'b1;
              r_fd_instr <= im_do;
              r_fd_pc    <= r_pc;
              r_pc       <= r_pc + ALIGN_STEP;
            end
          end else if (!w_stalled) begin
            r_fd_valid <= 1'b0;
          end
        end

        S_HOLD: begin
          if (w_flush) begin
            r_fd_valid <= 1'b0;
            r_pc       <= w_flush_pc;
            r_state    <= S_FETCH;
            r_req      <= 1'b1;
          end else if (!fd_stall) begin
            r_fd_valid <= 1'b0;
            r_state    <= S_FETCH;
            r_req      <= 1'b1;
          end
        end

        default: begin
          r_state <= S_BOOT;
          r_req   <= 1'b0;
        end
      endcase

      if (w_csr_we && (r_state != S_BOOT)) begin
        r_mepc   <= w_csr_epc;
        r_mcause <= w_csr_cause;
      end
    end
  end

  assign im_req   = r_req;
  assign im_addr  = r_pc;
  assign fd_valid = r_fd_valid;
  assign fd_instr = r_fd_instr;
  assign fd_pc    = r_fd_pc;
  assign mepc     = r_mepc;
  assign mcause   = r_mcause;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. A behavioural model of the fetch rules runs
// alongside the main instance and is compared every cycle; directed literal
// expectations pin the model at the interesting points. A second instance
// with IALIGN=2 answers every request at once and is checked only at a few
// hand-computed points.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0004;
  localparam int unsigned ALIGN = 4;

  logic        clk = 1'b0;
  logic        resetb;
  logic        im_req, im_ack, fd_valid, fd_stall;
  logic [31:0] im_addr, im_do, fd_instr, fd_pc;
  logic        redir_valid, trap_valid, mret;
  logic [31:0] redir_target, redir_src_pc, trap_pc, trap_cause;
  logic [31:0] mepc, mcause;

  logic        req_2, ack_2, fdv_2;
  logic [31:0] addr_2, do_2, fdi_2, fdp_2, mepc_2, mcause_2;

  logic        ack_auto, ack_man, cmp_en;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  // Memory responders: instance 1 is steered by the bench, instance 2
  // answers every request in the same cycle.
  assign im_ack = ack_auto ? im_req : ack_man;
  assign im_do  = instr_of(im_addr);
  assign ack_2  = req_2;
  assign do_2   = instr_of(addr_2);

  fetch_unit #(.XLEN(32), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .IALIGN(4)) u_dut (
    .clk(clk), .resetb(resetb),
    .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack), .im_do(im_do),
    .fd_valid(fd_valid), .fd_instr(fd_instr), .fd_pc(fd_pc), .fd_stall(fd_stall),
    .redir_valid(redir_valid), .redir_target(redir_target), .redir_src_pc(redir_src_pc),
    .trap_valid(trap_valid), .trap_pc(trap_pc), .trap_cause(trap_cause),
    .mret(mret), .mepc(mepc), .mcause(mcause)
  );

  fetch_unit #(.XLEN(32), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .IALIGN(2)) u_dut2 (
    .clk(clk), .resetb(resetb),
    .im_req(req_2), .im_addr(addr_2), .im_ack(ack_2), .im_do(do_2),
    .fd_valid(fdv_2), .fd_instr(fdi_2), .fd_pc(fdp_2), .fd_stall(fd_stall),
    .redir_valid(redir_valid), .redir_target(redir_target), .redir_src_pc(redir_src_pc),
    .trap_valid(trap_valid), .trap_pc(trap_pc), .trap_cause(trap_cause),
    .mret(mret), .mepc(mepc_2), .mcause(mcause_2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model of instance 1. m_req low with a valid instruction means
  // decode is holding it; m_wait marks the first cycle after reset release.
  // ---------------------------------------------------------------------------
  logic        m_wait, m_req, m_fdv, m_pend;
  logic [31:0] m_pc, m_pend_pc, m_fdi, m_fdp, m_mepc, m_mcause;

  always @(posedge clk or negedge resetb) begin : model
    logic        ack, stalled, flush;
    logic [31:0] tgt;
    if (!resetb) begin
      m_wait = 1'b1; m_req = 1'b0; m_pc = RV; m_fdv = 1'b0;
      m_fdi = '0; m_fdp = '0; m_mepc = '0; m_mcause = '0;
      m_pend = 1'b0; m_pend_pc = '0;
    end else if (m_wait) begin
      m_wait = 1'b0;
      m_req  = 1'b1;
    end else begin
      ack     = m_req && (ack_auto || ack_man);
      stalled = m_fdv && fd_stall;
      flush   = trap_valid || mret || redir_valid;
      tgt     = redir_target;
      if (trap_valid) begin
        tgt = TV; m_mepc = trap_pc; m_mcause = trap_cause;
      end else if (mret) begin
        tgt = m_mepc;
      end else if (redir_valid && (redir_target % ALIGN) != 0) begin
        tgt = TV; m_mepc = redir_src_pc; m_mcause = 0;
      end

      if (flush) begin
        m_fdv = 1'b0;
        if (m_req && !ack) begin
          m_pend = 1'b1; m_pend_pc = tgt;
        end else begin
          m_pc = tgt; m_pend = 1'b0;
        end
        m_req = 1'b1;
      end else if (!m_req) begin
        if (!fd_stall) begin
          m_fdv = 1'b0; m_req = 1'b1;
        end
      end else if (ack) begin
        if (m_pend) begin
          m_pc = m_pend_pc; m_pend = 1'b0; m_fdv = 1'b0;
        end else if (stalled) begin
          m_req = 1'b0;
        end else begin
          m_fdv = 1'b1; m_fdi = instr_of(m_pc); m_fdp = m_pc; m_pc = m_pc + ALIGN;
        end
      end else if (!stalled) begin
        m_fdv = 1'b0;
      end
    end
  end

  // Single compare process: every cycle outside reset.
  always @(posedge clk) begin
    #1;
    if (resetb && cmp_en) begin
      check("model im_req", 32'(im_req), 32'(m_req));
      check("model im_addr", im_addr, m_pc);
      check("model fd_valid", 32'(fd_valid), 32'(m_fdv));
      if (m_fdv) begin
        check("model fd_instr", fd_instr, m_fdi);
        check("model fd_pc", fd_pc, m_fdp);
      end
      check("model mepc", mepc, m_mepc);
      check("model mcause", mcause, m_mcause);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Directed stimulus; inputs change and literal checks sample on negedges.
  // ---------------------------------------------------------------------------
  initial begin
    resetb = 1'b0; cmp_en = 1'b0;
    fd_stall = 1'b0; redir_valid = 1'b0; redir_target = '0; redir_src_pc = '0;
    trap_valid = 1'b0; trap_pc = '0; trap_cause = '0; mret = 1'b0;
    ack_auto = 1'b0; ack_man = 1'b1;   // stray ack during reset
    tick(2);
    check("reset im_req", 32'(im_req), 0);
    check("reset im_addr", im_addr, RV);
    check("reset fd_valid", 32'(fd_valid), 0);
    check("reset fd_instr", fd_instr, 0);
    check("reset fd_pc", fd_pc, 0);
    check("reset mepc", mepc, 0);
    check("reset mcause", mcause, 0);

    // Release with ack still high: the boot cycle must ignore it.
    resetb = 1'b1; cmp_en = 1'b1;
    tick(1);
    check("boot im_req", 32'(im_req), 1);
    check("boot im_addr", im_addr, 32'h0);
    check("boot fd_valid", 32'(fd_valid), 0);
    ack_man = 1'b0; ack_auto = 1'b1;

    // Back-to-back fetches.
    tick(1);
    check("seq addr 4", im_addr, 32'h4);
    check("seq fd_pc 0", fd_pc, 32'h0);
    check("seq fd_valid", 32'(fd_valid), 1);
    tick(1);
    check("seq addr 8", im_addr, 32'h8);
    check("seq fd_pc 4", fd_pc, 32'h4);
    tick(1);
    check("seq addr C", im_addr, 32'hC);
    check("seq fd_pc 8", fd_pc, 32'h8);
    check("seq fd_instr 8", fd_instr, 32'h5A5A_001B);

    // Decode stall for three cycles.
    fd_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("hold im_req", 32'(im_req), 0);
      check("hold fd_valid", 32'(fd_valid), 1);
      check("hold fd_pc", fd_pc, 32'h8);
      check("hold fd_instr", fd_instr, 32'h5A5A_001B);
    end
    fd_stall = 1'b0;
    tick(1);
    check("resume im_req", 32'(im_req), 1);
    check("resume addr", im_addr, 32'hC);
    check("resume fd_valid", 32'(fd_valid), 0);
    tick(1);
    check("resume fd_pc", fd_pc, 32'hC);
    check("resume next addr", im_addr, 32'h10);

    // Redirect in the same cycle as an ack: that ack is dropped.
    redir_valid = 1'b1; redir_target = 32'h8; redir_src_pc = 32'h0;
    tick(1);
    check("redir+ack addr", im_addr, 32'h8);
    check("redir+ack fd_valid", 32'(fd_valid), 0);
    redir_valid = 1'b0; ack_auto = 1'b0; ack_man = 1'b0;

    // Redirect to 0x100 while the fetch at 0x8 is open; ack two cycles later.
    tick(1);
    redir_valid = 1'b1; redir_target = 32'h100;
    tick(1);
    check("pend addr held", im_addr, 32'h8);
    check("pend im_req", 32'(im_req), 1);
    redir_valid = 1'b0;
    tick(1);
    ack_man = 1'b1;
    tick(1);
    check("pend ack dropped", 32'(fd_valid), 0);
    check("pend new addr", im_addr, 32'h100);
    ack_man = 1'b0;

    // Two flushes before the ack: the latest one wins.
    redir_valid = 1'b1; redir_target = 32'h200;
    tick(1);
    redir_target = 32'h300;
    tick(1);
    check("multi addr held", im_addr, 32'h100);
    redir_valid = 1'b0; ack_man = 1'b1;
    tick(1);
    check("multi new addr", im_addr, 32'h300);
    check("multi fd_valid", 32'(fd_valid), 0);
    ack_man = 1'b0; ack_auto = 1'b1;
    tick(1);
    check("multi fd_pc", fd_pc, 32'h300);
    check("multi fd_instr", fd_instr, 32'h5A5A_0313);

    // Trap beats a simultaneous redirect; mret returns to mepc.
    trap_valid = 1'b1; trap_pc = 32'h20; trap_cause = 32'h2;
    redir_valid = 1'b1; redir_target = 32'h500;
    tick(1);
    check("trap mepc", mepc, 32'h20);
    check("trap mcause", mcause, 32'h2);
    check("trap addr", im_addr, TV);
    trap_valid = 1'b0; redir_valid = 1'b0;
    tick(1);
    check("trap fd_pc", fd_pc, 32'h4);
    mret = 1'b1;
    tick(1);
    check("mret addr", im_addr, 32'h20);
    check("mret mepc kept", mepc, 32'h20);
    check("mret mcause kept", mcause, 32'h2);
    mret = 1'b0;
    tick(1);
    check("mret fd_pc", fd_pc, 32'h20);

    // Misaligned redirect: a trap for IALIGN=4, a plain redirect for IALIGN=2.
    redir_valid = 1'b1; redir_target = 32'h102; redir_src_pc = 32'h40;
    tick(1);
    check("misalign mepc", mepc, 32'h40);
    check("misalign mcause", mcause, 32'h0);
    check("misalign addr", im_addr, TV);
    check("ialign2 addr", addr_2, 32'h102);
    check("ialign2 mcause", mcause_2, 32'h2);
    check("ialign2 mepc", mepc_2, 32'h20);

    // PC wraps modulo 2^32.
    redir_target = 32'hFFFF_FFFC; redir_src_pc = 32'h0;
    tick(1);
    check("wrap addr top", im_addr, 32'hFFFF_FFFC);
    redir_valid = 1'b0;
    tick(1);
    check("wrap addr 0", im_addr, 32'h0);
    check("wrap fd_pc", fd_pc, 32'hFFFF_FFFC);
    check("ialign2 wrap addr", addr_2, 32'hFFFF_FFFE);
    check("ialign2 wrap fd_pc", fdp_2, 32'hFFFF_FFFC);
    check("ialign2 wrap instr", fdi_2, 32'hA5A5_FFEF);
    check("ialign2 wrap valid", 32'(fdv_2), 1);

    // Reset in the middle of an open fetch, with a stray ack around it.
    ack_auto = 1'b0; ack_man = 1'b0;
    tick(1);
    check("open fetch addr", im_addr, 32'h0);
    check("open fetch fd_valid", 32'(fd_valid), 0);
    ack_man = 1'b1; resetb = 1'b0;
    #1;
    check("mid reset im_req", 32'(im_req), 0);
    check("mid reset fd_pc", fd_pc, 0);
    check("mid reset mepc", mepc, 0);
    check("mid reset mcause", mcause, 0);
    tick(1);
    resetb = 1'b1;
    tick(1);
    check("reboot im_req", 32'(im_req), 1);
    check("reboot addr", im_addr, RV);
    check("reboot fd_valid", 32'(fd_valid), 0);
    ack_man = 1'b0; ack_auto = 1'b1;
    tick(3);
    check("reboot fd_pc", fd_pc, 32'h8);
    check("reboot next addr", im_addr, 32'hC);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
